// File: rtl/dot_product_sequencer.sv
// Operand sequencer for one MAC: clear, stream VEC_LEN pairs, drain, capture and hold the result.
// Optional build macro DOTSEQ_ZERO_ON_ERR_EN: zero the captured total when the MAC reports overflow.
module dot_product_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
  parameter int VEC_LEN     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  input  logic                          op_valid,
  input  logic signed [DATA_WIDTH-1:0]  op_a,
  input  logic signed [DATA_WIDTH-1:0]  op_b,
  output logic                          op_ready,
  output logic                          mac_clr,
  output logic                          mac_running,
  output logic        [DATA_WIDTH-1:0]  mac_in1,
  output logic        [DATA_WIDTH-1:0]  mac_in2,
  input  logic        [ACCUM_WIDTH-1:0] mac_total,
  input  logic                          mac_err,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic        [ACCUM_WIDTH-1:0] res_data,
  output logic                          res_err
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic                   hs_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [ACCUM_WIDTH-1:0] cap_data_s;

  // Next-state and handshake decode
  always_comb begin
    state_s = state_r;
    hs_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_CLEAR;
        else       state_s = S_IDLE;
      end
      S_CLEAR: state_s = S_FEED;
      S_FEED: begin
        if (op_valid) begin
          hs_s = 1'b1;
          if (cnt_r == LAST_IDX) state_s = S_DRAIN;
          else                   state_s = S_FEED;
        end else begin
          state_s = S_FEED;
        end
      end
      S_DRAIN:   state_s = S_CAPTURE;
      S_CAPTURE: state_s = S_HOLD;
      S_HOLD: begin
        if (res_ready) state_s = S_IDLE;
        else           state_s = S_HOLD;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Value latched into the result register in CAPTURE
  always_comb begin
    cap_data_s = mac_total;
`ifdef DOTSEQ_ZERO_ON_ERR_EN
    if (mac_err) cap_data_s = '0;
    else         cap_data_s = mac_total;
`endif
  end

  // State, control outputs (registered from the next state) and operand staging
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      busy        <= 1'b0;
      op_ready    <= 1'b0;
      mac_clr     <= 1'b0;
      mac_running <= 1'b0;
      mac_in1     <= '0;
      mac_in2     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy        <= (state_s != S_IDLE);
      op_ready    <= (state_s == S_FEED);
      mac_clr     <= (state_s == S_CLEAR);
      res_valid   <= (state_s == S_HOLD);
      mac_running <= hs_s;
      if (hs_s) begin
        mac_in1 <= op_a;
        mac_in2 <= op_b;
      end
      if (state_r == S_CLEAR) cnt_r <= '0;
      else if (hs_s)          cnt_r <= cnt_r + CNT_W'(1);
      if (state_r == S_CAPTURE) begin
        res_data <= cap_data_s;
        res_err  <= mac_err;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: behavioural MAC, transaction-level result model, directed scenarios.
module tb_dot_product_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy;
  logic               op_valid = 1'b0;
  logic signed [15:0] op_a = 16'sd0;
  logic signed [15:0] op_b = 16'sd0;
  logic               op_ready;
  logic               mac_clr;
  logic               mac_running;
  logic        [15:0] mac_in1;
  logic        [15:0] mac_in2;
  logic        [31:0] mac_total = 32'd0;
  logic               mac_err = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic        [31:0] res_data;
  logic               res_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic signed [15:0] va [4];
  logic signed [15:0] vb [4];

  dot_product_sequencer #(.DATA_WIDTH(16), .ACCUM_WIDTH(32), .VEC_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .mac_clr(mac_clr), .mac_running(mac_running), .mac_in1(mac_in1), .mac_in2(mac_in2),
    .mac_total(mac_total), .mac_err(mac_err),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC downstream of the sequencer: signed product, wrapping sum, sticky overflow; not reset by rst_n
  always @(posedge clk) begin
    logic signed [31:0] p;
    logic signed [31:0] s;
    if (mac_clr) begin
      mac_total <= 32'd0;
      mac_err   <= 1'b0;
    end else if (mac_running) begin
      p = $signed(mac_in1) * $signed(mac_in2);
      s = $signed(mac_total) + p;
      mac_total <= s;
      mac_err   <= mac_err | ((mac_total[31] == p[31]) && (s[31] != p[31]));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact dot product of accepted pairs since the last clear
  logic signed [31:0] m_sum  = 32'sd0;
  logic               m_err  = 1'b0;
  logic               rst_q  = 1'b0;
  logic               p_hs   = 1'b0;
  logic        [15:0] p_a    = 16'd0;
  logic        [15:0] p_b    = 16'd0;
  logic        [15:0] l_in1  = 16'd0;
  logic        [15:0] l_in2  = 16'd0;
  logic               p_rv   = 1'b0;
  logic        [31:0] p_data = 32'd0;
  logic               p_rerr = 1'b0;

  always @(negedge clk) begin
    longint exact;
    logic [31:0] exp_data;
    if (!rst_q) begin
      chk("rst_ctl", {59'd0, busy, op_ready, mac_clr, mac_running, res_valid}, 64'd0);
      chk("rst_dat", {15'd0, mac_in1, mac_in2, res_err, 16'd0}, 64'd0);
      chk("rst_res", {32'd0, res_data}, 64'd0);
    end else begin
      chk("run_follows_hs", {63'd0, mac_running}, {63'd0, p_hs});
      if (p_hs) begin
        chk("in1_pass", {48'd0, mac_in1}, {48'd0, p_a});
        chk("in2_pass", {48'd0, mac_in2}, {48'd0, p_b});
      end else begin
        chk("in1_hold", {48'd0, mac_in1}, {48'd0, l_in1});
        chk("in2_hold", {48'd0, mac_in2}, {48'd0, l_in2});
      end
      chk("clr_run_excl", {63'd0, mac_clr & mac_running}, 64'd0);
      if (op_ready) chk("ready_busy", {63'd0, busy}, 64'd1);
      if (res_valid && !p_rv) begin
        exp_data = m_sum;
`ifdef DOTSEQ_ZERO_ON_ERR_EN
        if (m_err) exp_data = 32'd0;
`endif
        chk("model_data", {32'd0, res_data}, {32'd0, exp_data});
        chk("model_err", {63'd0, res_err}, {63'd0, m_err});
      end
      if (res_valid && p_rv) begin
        chk("hold_data", {32'd0, res_data}, {32'd0, p_data});
        chk("hold_err", {63'd0, res_err}, {63'd0, p_rerr});
      end
    end
    if (mac_clr) begin
      m_sum = 32'sd0;
      m_err = 1'b0;
    end
    p_hs = op_valid && op_ready && rst_n;
    if (p_hs) begin
      exact = longint'(m_sum) + longint'(op_a) * longint'(op_b);
      if (exact > 64'sd2147483647 || exact < -64'sd2147483648) m_err = 1'b1;
      m_sum = exact[31:0];
    end
    p_a    = op_a;
    p_b    = op_b;
    l_in1  = mac_in1;
    l_in2  = mac_in2;
    p_rv   = res_valid;
    p_data = res_data;
    p_rerr = res_err;
    rst_q  = rst_n;
  end

  task automatic run_dp(input int gap, input int hold_wait, input bit start_in_hold,
                        output int lat, output logic [31:0] data, output logic err);
    int  idx;
    int  gapcnt;
    int  t0;
    bit  hs;
    bit  done;
    idx = 0; gapcnt = 0; hs = 1'b0; done = 1'b0;
    lat = -1; data = 32'd0; err = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    res_ready = 1'b0;
    t0 = cyc;
    for (int n = 0; n < 100 && !done; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (hs) begin
        idx++;
        gapcnt = gap;
      end
      if (gapcnt > 0) begin
        op_valid = 1'b0;
        gapcnt--;
      end else if (idx < 4) begin
        op_valid = 1'b1;
        op_a = va[idx];
        op_b = vb[idx];
      end else begin
        op_valid = 1'b0;
      end
      hs = op_valid && op_ready;
      if (res_valid) begin
        lat = cyc - t0; data = res_data; err = res_err; done = 1'b1;
      end
    end
    op_valid = 1'b0;
    if (!done) $display("FAIL timeout: no res_valid within 100 cycles");
    for (int h = 0; h < hold_wait; h++) begin
      start = start_in_hold && (h % 2 == 0);
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, res_valid}, 64'd1);
      chk("bp_data", {32'd0, res_data}, {32'd0, data});
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_valid", {63'd0, res_valid}, 64'd0);
  endtask

  task automatic set_vec(input int a0, a1, a2, a3, b0, b1, b2, b3);
    va[0] = 16'(a0); va[1] = 16'(a1); va[2] = 16'(a2); va[3] = 16'(a3);
    vb[0] = 16'(b0); vb[1] = 16'(b1); vb[2] = 16'(b2); vb[3] = 16'(b3);
  endtask

  initial begin
    int          lat;
    logic [31:0] d;
    logic        e;
    int          k;
    bit          hs;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_res", {32'd0, res_data}, 64'd0);

    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    run_dp(0, 0, 1'b0, lat, d, e);
    chk("basic_lat", lat, 64'd8);
    chk("basic_data", {32'd0, d}, 64'd70);
    chk("basic_err", {63'd0, e}, 64'd0);

    set_vec(-3, 2, -1, 0, 4, -5, -6, 7);
    run_dp(0, 0, 1'b0, lat, d, e);
    chk("signed_lat", lat, 64'd8);
    chk("signed_data", {32'd0, d}, 64'h0000_0000_FFFF_FFF0);
    chk("signed_err", {63'd0, e}, 64'd0);

    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    run_dp(2, 0, 1'b0, lat, d, e);
    chk("stall_lat", lat, 64'd14);
    chk("stall_data", {32'd0, d}, 64'd70);

    set_vec(1, 1, 1, 1, 2, 3, 4, 5);
    run_dp(0, 5, 1'b1, lat, d, e);
    chk("bp_result", {32'd0, d}, 64'd14);
    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    run_dp(0, 0, 1'b0, lat, d, e);
    chk("after_bp_lat", lat, 64'd8);
    chk("after_bp_data", {32'd0, d}, 64'd70);

    set_vec(-32768, -32768, -32768, 0, -32768, -32768, -32768, 0);
    run_dp(0, 0, 1'b0, lat, d, e);
    chk("ovf_err", {63'd0, e}, 64'd1);
`ifdef DOTSEQ_ZERO_ON_ERR_EN
    chk("ovf_data", {32'd0, d}, 64'd0);
`else
    chk("ovf_data", {32'd0, d}, 64'h0000_0000_C000_0000);
`endif

    // Mid-FEED reset after two accepted pairs
    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    @(posedge clk); #1;
    start = 1'b1;
    k = 0;
    for (int n = 0; n < 20 && k < 2; n++) begin
      op_valid = 1'b1; op_a = va[k]; op_b = vb[k];
      hs = op_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) k++;
    end
    chk("midrst_hs", k, 64'd2);
    op_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ctl", {59'd0, busy, op_ready, mac_clr, mac_running, res_valid}, 64'd0);
    chk("midrst_in", {32'd0, mac_in1, mac_in2}, 64'd0);
    chk("midrst_res", {31'd0, res_err, res_data}, 64'd0);
    run_dp(0, 0, 1'b0, lat, d, e);
    chk("post_rst_lat", lat, 64'd8);
    chk("post_rst_data", {32'd0, d}, 64'd70);
    chk("post_rst_err", {63'd0, e}, 64'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
